// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//
// Receive-side byte buffer placed directly after the UART receiver. Each byte
// the receiver strobes in with i_RX_DV is stored in a circular FIFO, and the
// consuming logic pops bytes at its own pace through a registered read port.
// The block reports empty, full, occupancy and a sticky overrun flag for bytes
// dropped while full.
//
// Optional feature: define UART_RX_FIFO_WATERMARK_EN to build the occupancy
// watermark compare (o_Watermark = count >= WATERMARK, registered with count).
// Without the macro, o_Watermark is tied to 0 and the port list is unchanged.
//
// Parameters:
//   ADDR_W     address width, depth is DEPTH = 2**ADDR_W bytes
//   WATERMARK  occupancy threshold for o_Watermark, legal range 1..DEPTH
//
// Ports:
//   i_Clock        clock (shared with the UART receiver)
//   i_Reset        asynchronous active-high reset
//   i_RX_DV        one-cycle strobe: i_RX_Byte is valid this cycle
//   i_RX_Byte      received byte
//   i_Rd_En        read request, pops one byte when not empty
//   o_Rd_Data      registered read data, held until the next accepted read
//   o_Rd_Valid     one-cycle pulse the cycle after an accepted read
//   o_Empty        count == 0
//   o_Full         count == DEPTH
//   o_Count        occupancy, 0..DEPTH
//   o_Overrun      sticky: a byte was dropped because the FIFO was full
//   i_Overrun_Clr  synchronous clear of o_Overrun (a coincident set wins)
//   o_Watermark    count >= WATERMARK (watermark build only, else 0)
//
// Handshake: the write side has no back-pressure; a strobe on i_RX_DV is
// either stored or, when full with no read in the same cycle, dropped and
// flagged in o_Overrun. The read side is request/response: i_Rd_En is accepted
// only while count > 0, and an accepted read is answered exactly one cycle
// later by o_Rd_Valid together with the new o_Rd_Data. Requests while empty are
// ignored and produce no o_Rd_Valid.

module uart_rx_fifo #(
    parameter int ADDR_W    = 4,
    parameter int WATERMARK = 12
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    input  logic              i_Rd_En,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Rd_Valid,
    output logic              o_Empty,
    output logic              o_Full,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overrun,
    input  logic              i_Overrun_Clr,
    output logic              o_Watermark
);

    localparam int                DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE    = 1;

    // Elaboration-time guard on the threshold range.
    if (WATERMARK < 1 || WATERMARK > DEPTH) begin : g_bad_watermark
        $error("uart_rx_fifo: WATERMARK must be in 1..DEPTH");
    end

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              rd_accept;
    logic              wr_accept;
    logic              overrun_set;

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write when it is read at the same time. An empty FIFO never forwards the
    // incoming byte to the read port.
    always_comb begin
        rd_accept   = i_Rd_En && (count != '0);
        wr_accept   = i_RX_DV && ((count != FULL_COUNT) || rd_accept);
        overrun_set = i_RX_DV && !wr_accept;
    end

    always_comb begin
        count_next = count;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    // Storage array has no reset; only pointers and count define contents.
    always_ff @(posedge i_Clock) begin
        if (wr_accept) begin
            mem[wr_ptr] <= i_RX_Byte;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Rd_Data  <= 8'h00;
            o_Rd_Valid <= 1'b0;
            o_Overrun  <= 1'b0;
        end else begin
            count      <= count_next;
            o_Rd_Valid <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                o_Rd_Data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
            // Set has priority over clear so a drop is never missed.
            if (overrun_set) begin
                o_Overrun <= 1'b1;
            end else if (i_Overrun_Clr) begin
                o_Overrun <= 1'b0;
            end
        end
    end

    assign o_Empty = (count == '0);
    assign o_Full  = (count == FULL_COUNT);
    assign o_Count = count;

`ifdef UART_RX_FIFO_WATERMARK_EN
    localparam logic [ADDR_W:0] WM_COUNT = (ADDR_W + 1)'(WATERMARK);

    logic watermark_q;

    // Computed from count_next so the flag changes on the same edge as count.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            watermark_q <= 1'b0;
        end else begin
            watermark_q <= (count_next >= WM_COUNT);
        end
    end

    assign o_Watermark = watermark_q;
`else
    assign o_Watermark = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver presents with its one-cycle data-valid strobe into a circular FIFO, and lets the consuming logic read bytes at its own pace through a registered read handshake. It reports empty, full, occupancy and a sticky overrun flag for bytes lost while full.

## Interface
- ADDR_W, 4: address width; FIFO depth is DEPTH = 2**ADDR_W bytes.
- WATERMARK, 12: occupancy threshold for o_Watermark; legal range 1..DEPTH; only used with UART_RX_FIFO_WATERMARK_EN.
- i_Clock  input  1  single clock for the whole block; same clock as the UART receiver.
- i_Reset  input  1  reset; asynchronous, active-high.
- i_RX_DV  input  1  one-cycle strobe from the receiver: i_RX_Byte is valid this cycle.
- i_RX_Byte  input  8  received byte, sampled only when i_RX_DV=1.
- i_Rd_En  input  1  read request; pops one byte if not empty.
- o_Rd_Data  output  8  registered read data; holds its value until the next accepted read.
- o_Rd_Valid  output  1  one-cycle pulse, the cycle after an accepted read: o_Rd_Data is new.
- o_Empty  output  1  count == 0.
- o_Full  output  1  count == DEPTH.
- o_Count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- o_Overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- i_Overrun_Clr  input  1  synchronous clear of o_Overrun.
- o_Watermark  output  1  occupancy at or above WATERMARK (see Configuration).

## Operation
- Storage: DEPTH x 8 array; write pointer and read pointer of ADDR_W bits each, both wrapping modulo DEPTH; separate count register of ADDR_W+1 bits. Array contents are not reset.
- Write accept: i_RX_DV=1 and (count < DEPTH, or an accepted read occurs in the same cycle). The byte goes to mem[wr_ptr] and wr_ptr increments.
- Write reject: i_RX_DV=1, count == DEPTH, and no accepted read in the same cycle. The byte is discarded, and pointers and count are unchanged. o_Overrun is set.
- Read accept: i_Rd_En=1 and count > 0. mem[rd_ptr] is registered into o_Rd_Data, rd_ptr increments, and o_Rd_Valid=1 on the next cycle. i_Rd_En while empty is ignored, and o_Rd_Data is unchanged.
- Simultaneous write and read:
  - When 0 < count < DEPTH, both are accepted and count is unchanged.
  - When full, both are accepted and count stays DEPTH.
  - When empty, only the write is accepted; there is no fall-through and count becomes 1.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Overrun: if a set and i_Overrun_Clr occur in the same cycle, the set wins.
- o_Empty, o_Full, o_Count and o_Watermark are driven from registered count, so they update the cycle after the causing event.
- Reset (any time, including mid-read or mid-write):
  - Pointers = 0, count = 0, o_Rd_Data = 8'h00, o_Rd_Valid = 0, o_Overrun = 0.
  - As a result, o_Empty = 1, o_Full = 0, o_Count = 0, o_Watermark = 0.
  - A pending i_RX_DV strobe coincident with reset is lost.

## Timing
- Write-to-visible latency: a byte strobed in cycle N raises count and clears o_Empty at edge N+1. It can be read by asserting i_Rd_En in cycle N+1, and data appears at N+2.
- Read latency: 1 cycle, from i_Rd_En sampled high to o_Rd_Data/o_Rd_Valid.
- Sustained throughput: one read per cycle with i_Rd_En held high. Reads stop being accepted the cycle count reaches 0.
- The receiver produces at most one strobe per CLKS_PER_BIT*10 cycles; the block still accepts a write every cycle.

## Configuration
- UART_RX_FIFO_WATERMARK_EN defined: o_Watermark = (count >= WATERMARK), registered with count.
- Undefined: the watermark compare logic is not built and o_Watermark is tied to 0. The port list is identical in both builds.

## Test plan
- Reset then idle: o_Empty=1, o_Full=0, o_Count=0, o_Overrun=0, o_Rd_Data=8'h00. An i_Rd_En pulse gives no o_Rd_Valid.
- Write 8'hA5, 8'h3C, then read twice: o_Rd_Data=8'hA5 then 8'h3C, each with a one-cycle o_Rd_Valid, ending with o_Count=0 and o_Empty=1.
- With ADDR_W=4:
  - Write 17 bytes 8'h00..8'h10: o_Full=1 after the 16th and o_Overrun=1 after the 17th.
  - Reading 16 bytes returns 8'h00..8'h0F; 8'h10 is absent.
  - i_Overrun_Clr then clears the flag.
- When full, assert i_RX_DV=1 (8'hEE) and i_Rd_En=1 in the same cycle: the oldest byte is read, o_Count stays 16, and o_Overrun stays 0. 8'hEE is the last byte read out.
- Pointer wrap: 40 write/read pairs with the FIFO never exceeding 3 entries. Data order is preserved across wrap and o_Count never exceeds 3.
- Watermark build with WATERMARK=12: o_Watermark rises the cycle after the 12th write and falls the cycle after the read that takes count to 11. In the non-macro build it stays 0 throughout.
- Assert i_Reset with 5 bytes stored and o_Overrun=1: all outputs return to reset values within the same cycle. Subsequent writes start at address 0.
